// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order request -> ALU -> response pipeline with RISC-V funct3/funct7 decode.
// Define ALU_ISSUE_BRANCH_EN to add branch-condition evaluation (req_branch_i / rsp_taken_o).
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic             req_funct7b5_i,
  input  logic             req_imm_i,
`ifdef ALU_ISSUE_BRANCH_EN
  input  logic             req_branch_i,
  output logic             rsp_taken_o,
`endif
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [3:0]       alu_flags_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_illegal_o
);

  // Control codes follow the alu_pkg numbering of the connected ALU.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  logic issue_v_q, issue_v_d;
  logic rsp_v_q, rsp_v_d;
  logic accept, advance;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  logic [WIDTH-1:0] issue_a_q, issue_b_q;
  logic [3:0]       issue_ctrl_q;
  logic [TAG_W-1:0] issue_tag_q;
  logic             issue_illegal_q;

  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_illegal_q;

`ifdef ALU_ISSUE_BRANCH_EN
  logic       issue_branch_q;
  logic [2:0] issue_f3_q;
  logic       rsp_taken_q;
  logic       taken;
`endif

  // Occupancy (EMPTY/ONE/TWO) is carried by the two stage valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_v_q <= 1'b0;
      rsp_v_q   <= 1'b0;
    end else begin
      issue_v_q <= issue_v_d;
      rsp_v_q   <= rsp_v_d;
    end
  end

  always_comb begin
    issue_v_d = issue_v_q;
    rsp_v_d   = rsp_v_q;
    if (advance) begin
      rsp_v_d = 1'b1;
    end else if (rsp_ready_i) begin
      rsp_v_d = 1'b0;
    end
    if (accept) begin
      issue_v_d = 1'b1;
    end else if (advance) begin
      issue_v_d = 1'b0;
    end
  end

  always_comb begin
    advance     = issue_v_q & (~rsp_v_q | rsp_ready_i);
    req_ready_o = ~issue_v_q | advance;
    accept      = req_valid_i & req_ready_o;
    rsp_valid_o = rsp_v_q;
  end

  // Instruction decode of the incoming request.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    unique case (req_funct3_i)
      3'b000: dec_ctrl = (!req_imm_i && req_funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        dec_ctrl    = ALU_SLL;
        dec_illegal = req_funct7b5_i;
      end
      3'b010: dec_ctrl = ALU_SLT;
      3'b011: dec_ctrl = ALU_SLTU;
      3'b100: dec_ctrl = ALU_XOR;
      3'b101: dec_ctrl = req_funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110: dec_ctrl = ALU_OR;
      3'b111: dec_ctrl = ALU_AND;
    endcase
    // R-type only allows funct7[5] on ADD/SUB and SRL/SRA.
    if (!req_imm_i && req_funct7b5_i && (req_funct3_i != 3'b000) && (req_funct3_i != 3'b101)) begin
      dec_illegal = 1'b1;
    end
`ifdef ALU_ISSUE_BRANCH_EN
    if (req_branch_i) begin
      dec_ctrl    = ALU_SUB;
      dec_illegal = (req_funct3_i[2:1] == 2'b01);
    end
`endif
    if (dec_illegal) begin
      dec_ctrl = ALU_ADD;
    end
  end

  // Issue register: holds the last issued operands/control when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_a_q       <= '0;
      issue_b_q       <= '0;
      issue_ctrl_q    <= ALU_ADD;
      issue_tag_q     <= '0;
      issue_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
      issue_branch_q  <= 1'b0;
      issue_f3_q      <= 3'b000;
`endif
    end else if (accept) begin
      issue_a_q       <= req_a_i;
      issue_b_q       <= req_b_i;
      issue_ctrl_q    <= dec_ctrl;
      issue_tag_q     <= req_tag_i;
      issue_illegal_q <= dec_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
      issue_branch_q  <= req_branch_i;
      issue_f3_q      <= req_funct3_i;
`endif
    end
  end

  assign alu_a_o    = issue_a_q;
  assign alu_b_o    = issue_b_q;
  assign alu_ctrl_o = issue_ctrl_q;

`ifdef ALU_ISSUE_BRANCH_EN
  // Flags are {OF,N,C,Z}; C is no-borrow for the forced subtraction.
  always_comb begin
    taken = 1'b0;
    case (issue_f3_q)
      3'b000:  taken = alu_flags_i[0];
      3'b001:  taken = ~alu_flags_i[0];
      3'b100:  taken = alu_flags_i[2] ^ alu_flags_i[3];
      3'b101:  taken = ~(alu_flags_i[2] ^ alu_flags_i[3]);
      3'b110:  taken = ~alu_flags_i[1];
      3'b111:  taken = alu_flags_i[1];
      default: taken = 1'b0;
    endcase
    if (!issue_branch_q || issue_illegal_q) begin
      taken = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_result_q  <= '0;
      rsp_flags_q   <= 4'b0000;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
      rsp_taken_q   <= 1'b0;
`endif
    end else if (advance) begin
      rsp_result_q  <= issue_illegal_q ? '0 : alu_result_i;
      rsp_flags_q   <= issue_illegal_q ? 4'b0000 : alu_flags_i;
      rsp_tag_q     <= issue_tag_q;
      rsp_illegal_q <= issue_illegal_q;
`ifdef ALU_ISSUE_BRANCH_EN
      rsp_taken_q   <= taken;
`endif
    end
  end

  assign rsp_result_o  = rsp_result_q;
  assign rsp_flags_o   = rsp_flags_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_illegal_o = rsp_illegal_q;
`ifdef ALU_ISSUE_BRANCH_EN
  assign rsp_taken_o   = rsp_taken_q;
`endif

endmodule
